// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - multiplexed seven-segment scan controller with tear-free shadow data
module fnd_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int DEAD_CYCLES = 2,
  parameter int ON_CYCLES   = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_update,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blank,
  output logic [DIGITS-1:0]     o_digit,
  output logic [7:0]            o_seg,
  output logic                  o_frame
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAXC = (DEAD_CYCLES > ON_CYCLES) ? DEAD_CYCLES : ON_CYCLES;
  localparam int CNTW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNTW-1:0] DEAD_LAST = CNTW'(DEAD_CYCLES - 1);
  localparam logic [CNTW-1:0] ON_LAST   = CNTW'(ON_CYCLES - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_ON} state_t;

  state_t                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]     digit_q, digit_d;
  logic [7:0]            seg_q, seg_d;
  logic                  frame_q, frame_d;
  logic [4*DIGITS-1:0]   shd_val_q, shd_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     shd_dp_q, shd_dp_d, pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]     shd_blank_q, shd_blank_d, pend_blank_q, pend_blank_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  load;
  logic [3:0]            nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;  4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;  4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;  4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;  4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = 1'b0;
    load    = 1'b0;
    if (!i_enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_DEAD;
          cnt_d   = '0;
          idx_d   = '0;
          load    = 1'b1;
        end
        S_DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = S_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_ON: begin
          if (cnt_q == ON_LAST) begin
            state_d = S_DEAD;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              frame_d = 1'b1;
              load    = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Shadow only moves at frame starts; an update on that same edge bypasses pending.
  always_comb begin
    shd_val_d    = shd_val_q;
    shd_dp_d     = shd_dp_q;
    shd_blank_d  = shd_blank_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    if (i_update && load) begin
      shd_val_d    = i_value;
      shd_dp_d     = i_dp;
      shd_blank_d  = i_blank;
      pend_valid_d = 1'b0;
    end else begin
      if (load && pend_valid_q) begin
        shd_val_d    = pend_val_q;
        shd_dp_d     = pend_dp_q;
        shd_blank_d  = pend_blank_q;
        pend_valid_d = 1'b0;
      end
      if (i_update) begin
        pend_val_d   = i_value;
        pend_dp_d    = i_dp;
        pend_blank_d = i_blank;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    digit_d = '1;
    seg_d   = 8'hFF;
    nib     = shd_val_d[{idx_d, 2'b00} +: 4];
    if (state_d == S_ON) begin
      seg_d = {~shd_dp_d[idx_d], decode(nib)};
      if (!shd_blank_d[idx_d]) digit_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      digit_q      <= '1;
      seg_q        <= 8'hFF;
      frame_q      <= 1'b0;
      shd_val_q    <= '0;
      shd_dp_q     <= '0;
      shd_blank_q  <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      digit_q      <= digit_d;
      seg_q        <= seg_d;
      frame_q      <= frame_d;
      shd_val_q    <= shd_val_d;
      shd_dp_q     <= shd_dp_d;
      shd_blank_q  <= shd_blank_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign o_digit = digit_q;
  assign o_seg   = seg_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb/tb_fnd_scan_ctrl.sv - scoreboard bench for fnd_scan_ctrl (DIGITS=4, DEAD=2, ON=6)
module tb_fnd_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        update;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  dig;
  logic [7:0]  seg;
  logic        frame;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] dig;
    logic [7:0] seg;
    logic       frm;
  } exp_t;

  exp_t       sb[$];
  logic [6:0] dec [16];

  fnd_scan_ctrl #(.DIGITS(4), .DEAD_CYCLES(2), .ON_CYCLES(6)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_enable  (enable),
    .i_update  (update),
    .i_value   (value),
    .i_dp      (dp),
    .i_blank   (blank),
    .o_digit   (dig),
    .o_seg     (seg),
    .o_frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_off(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.dig = 4'hF;
      e.seg = 8'hFF;
      e.frm = 1'b0;
      sb.push_back(e);
    end
  endtask

  // One frame: each digit slot is 2 dead cycles then 6 driven cycles.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                            input bit first);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 8; c++) begin
        if (c < 2) begin
          e.dig = 4'hF;
          e.seg = 8'hFF;
        end else begin
          e.dig = b[k] ? 4'hF : ~(4'b0001 << k);
          e.seg = {~d[k], dec[v[4*k +: 4]]};
        end
        e.frm = (!first && k == 0 && c == 0);
        sb.push_back(e);
      end
    end
  endtask

  task automatic run(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_sb_avail"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_digit"}, 32'(dig), 32'(e.dig));
        check({tag, "_seg"}, 32'(seg), 32'(e.seg));
        check({tag, "_frame"}, 32'(frame), 32'(e.frm));
      end
    end
  endtask

  initial begin
    dec = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst_n  = 1'b0;
    enable = 1'b0;
    update = 1'b0;
    value  = '0;
    dp     = '0;
    blank  = '0;
    repeat (2) tick();
    check("reset_digit", 32'(dig), 32'hF);
    check("reset_seg", 32'(seg), 32'hFF);
    check("reset_frame", 32'(frame), 32'h0);
    rst_n = 1'b1;
    push_off(2);
    run(2, "idle");

    update = 1'b1;
    value  = 16'h4321;
    push_off(1);
    run(1, "upd_idle");
    update = 1'b0;
    enable = 1'b1;
    push_frame(16'h4321, 4'b0000, 4'b0000, 1'b1);
    push_frame(16'h4321, 4'b0000, 4'b0000, 1'b0);
    push_frame(16'h8888, 4'b0000, 4'b0000, 1'b0);
    push_frame(16'h4321, 4'b0001, 4'b0100, 1'b0);
    push_frame(16'h4321, 4'b0000, 4'b0000, 1'b0);
    run(32, "frame0");

    run(12, "frame1");
    update = 1'b1;
    value  = 16'h8888;
    run(1, "frame1");
    update = 1'b0;
    run(19, "frame1");

    run(12, "frame2");
    update = 1'b1;
    value  = 16'h4321;
    dp     = 4'b0001;
    blank  = 4'b0100;
    run(1, "frame2");
    update = 1'b0;
    run(19, "frame2");

    run(12, "blank_dp");
    update = 1'b1;
    dp     = 4'b0000;
    blank  = 4'b0000;
    run(1, "blank_dp");
    update = 1'b0;
    run(19, "blank_dp");

    run(21, "pre_disable");
    sb.delete();
    enable = 1'b0;
    push_off(3);
    run(3, "disabled");

    enable = 1'b1;
    push_frame(16'h4321, 4'b0000, 4'b0000, 1'b1);
    push_frame(16'hABCD, 4'b0000, 4'b0000, 1'b0);
    run(32, "restart");
    update = 1'b1;
    value  = 16'hABCD;
    run(1, "coincide");
    update = 1'b0;
    check("coincide_pend_valid", 32'(dut.pend_valid_q), 32'h0);
    run(4, "coincide");

    sb.delete();
    rst_n = 1'b0;
    #2;
    check("async_reset_digit", 32'(dig), 32'hF);
    check("async_reset_seg", 32'(seg), 32'hFF);
    check("async_reset_frame", 32'(frame), 32'h0);
    enable = 1'b0;
    repeat (3) begin
      tick();
      check("reset_hold_digit", 32'(dig), 32'hF);
      check("reset_hold_seg", 32'(seg), 32'hFF);
    end
    rst_n = 1'b1;
    push_off(3);
    run(3, "post_reset_idle");

    enable = 1'b1;
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b1);
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0);
    run(33, "cleared_shadow");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
